// File: rtl/tagged_flow_collector.sv
// ---------------------------------------------------------------------------
// tagged_flow_collector
//
// Demultiplexes a single tagged write stream into FLUX independent show-ahead
// FIFOs, one per flow. Each flow counts the elements its consumer pops. Once
// BLOCK_LEN elements have been popped, the flow reports completion on done[f].
// It then refuses new writes until clear[f] re-arms it.
//
// Ports
//   clk        : clock; all state updates on the rising edge
//   rst        : asynchronous active-low reset
//   in_din     : {tag[TAG_W-1:0], payload[DATA_W-1:0]}
//   in_write   : in_din valid this cycle
//   in_full    : per-flow FIFO full (combinational from occupancy)
//   out_data   : per-flow head-of-FIFO payload, flow f in slice f
//   out_valid  : per-flow head valid
//   out_ready  : per-flow consumer accept
//   clear      : per-flow pulse that returns a finished flow to idle
//   done       : per-flow block-complete flag
//   err_drop   : sticky, a write hit a full or finished flow
//   err_tag    : sticky, a write carried a tag >= FLUX
// ---------------------------------------------------------------------------
module tagged_flow_collector #(
    parameter int FLUX      = 4,
    parameter int TAG_W     = 2,
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 16,
    parameter int BLOCK_LEN = 256
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [TAG_W+DATA_W-1:0]  in_din,
    input  logic                     in_write,
    output logic [FLUX-1:0]          in_full,
    output logic [FLUX*DATA_W-1:0]   out_data,
    output logic [FLUX-1:0]          out_valid,
    input  logic [FLUX-1:0]          out_ready,
    input  logic [FLUX-1:0]          clear,
    output logic [FLUX-1:0]          done,
    output logic                     err_drop,
    output logic                     err_tag
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PC_W  = $clog2(BLOCK_LEN + 1);

    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [PC_W-1:0]  BLOCK_CNT = PC_W'(BLOCK_LEN);
    // One extra bit so FLUX == 2**TAG_W is representable.
    localparam logic [TAG_W:0]   FLUX_V    = (TAG_W + 1)'(FLUX);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACTIVE,
        ST_DONE
    } flow_state_e;

    logic [TAG_W-1:0]  in_tag;
    logic [DATA_W-1:0] in_payload;
    logic              tag_ok;
    logic [FLUX-1:0]   drop_vec;

    assign in_tag     = in_din[TAG_W+DATA_W-1:DATA_W];
    assign in_payload = in_din[DATA_W-1:0];
    assign tag_ok     = {1'b0, in_tag} < FLUX_V;

    for (genvar f = 0; f < FLUX; f++) begin : g_flow
        logic [DATA_W-1:0] mem [DEPTH];
        logic [PTR_W-1:0]  wr_ptr;
        logic [PTR_W-1:0]  rd_ptr;
        logic [CNT_W-1:0]  count;
        logic [PC_W-1:0]   pop_cnt;
        logic [PC_W-1:0]   pop_cnt_nxt;
        flow_state_e       state;
        flow_state_e       state_nxt;
        logic              hit;
        logic              full;
        logic              push;
        logic              pop;
        logic              valid;

        assign hit   = in_write && tag_ok && (in_tag == TAG_W'(f));
        assign full  = (count == FULL_CNT);
        assign valid = (count != '0);
        // A finished flow refuses new data until it is re-armed by clear.
        assign push  = hit && !full && (state != ST_DONE);
        assign pop   = valid && out_ready[f];

        assign drop_vec[f] = hit && (full || (state == ST_DONE));

        // Pointers wrap naturally because DEPTH is a power of 2.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                // NOTE: non-blocking (<=) in every clocked block so all
                // registers update together from pre-edge values.
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                case ({push, pop})
                    2'b10:   count <= count + 1'b1;
                    2'b01:   count <= count - 1'b1;
                    default: ;
                endcase
            end
        end

        // NOTE: the storage array has no reset; an empty FIFO masks its
        // contents, so clearing it would only add reset fan-out.
        always_ff @(posedge clk) begin
            if (push) mem[wr_ptr] <= in_payload;
        end

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state   <= ST_IDLE;
                pop_cnt <= '0;
            end else begin
                state   <= state_nxt;
                pop_cnt <= pop_cnt_nxt;
            end
        end

        always_comb begin
            // NOTE: defaults first so every path assigns both outputs and no
            // latch is inferred.
            state_nxt   = state;
            pop_cnt_nxt = pop_cnt;
            case (state)
                ST_IDLE: begin
                    if (push) state_nxt = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (pop && (pop_cnt != BLOCK_CNT)) begin
                        pop_cnt_nxt = pop_cnt + 1'b1;
                        if (pop_cnt_nxt == BLOCK_CNT) state_nxt = ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Residual data may still drain here; it is not counted.
                    if (clear[f]) begin
                        state_nxt   = ST_IDLE;
                        pop_cnt_nxt = '0;
                    end
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    pop_cnt_nxt = '0;
                end
            endcase
        end

        assign in_full[f]   = full;
        assign out_valid[f] = valid;
        // Gate the head with valid so out_data reads 0 whenever empty.
        assign out_data[f*DATA_W +: DATA_W] = valid ? mem[rd_ptr] : '0;
        assign done[f]      = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_drop <= 1'b0;
            err_tag  <= 1'b0;
        end else begin
            if (|drop_vec)             err_drop <= 1'b1;
            if (in_write && !tag_ok)   err_tag  <= 1'b1;
        end
    end

endmodule
